muldiv_65ce02: RTL and testbench
================================

MULDIV_65CE02 -- requirements
Module: muldiv_65ce02

Interface
REQ-001 Parameters SHALL be none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 RDY  input  1  global stall; when low, no state, register or DO update occurs.
REQ-005 CS  input  1  register select; access valid only when high.
REQ-006 WE  input  1  1 = write DI to register AB, 0 = read.
REQ-007 AB  input  2  register address.
REQ-008 DI  input  8  write data.
REQ-009 DO  output  8  registered read data.
REQ-010 BUSY  output  1  high while an operation is in progress.

Function
REQ-011 Write map: 0 = A/dividend low, 1 = dividend high, 2 = B/divisor, 3 = control (bit0 start multiply, bit1 start divide).
REQ-012 Read map: 0 = result low, 1 = result high, 2 = remainder, 3 = status {BUSY, DZ, 5'b0, DONE}.
REQ-013 DO SHALL present the addressed register on the first clk edge with RDY=1 after a read access (latency 1); DO holds otherwise.
REQ-014 FSM states SHALL be IDLE, MUL and DIV, with a 4-bit step counter.
REQ-015 In IDLE, a control write with bit0=1 SHALL enter MUL and clear DONE and DZ; bit1=1 alone SHALL enter DIV; bit0 takes priority when both bits are set.
REQ-016 MUL SHALL compute unsigned {dividend_lo} x B as a 16-bit result by shift-add, one bit per RDY cycle, over exactly 8 cycles, then return to IDLE with DONE=1.
REQ-017 DIV SHALL compute unsigned 16/8 restoring division, yielding a 16-bit quotient and an 8-bit remainder, over exactly 16 RDY cycles, then return to IDLE with DONE=1.
REQ-018 Divisor 0 SHALL complete in 1 cycle: quotient = 16'hFFFF, remainder = dividend low byte, DZ=1, DONE=1.
REQ-019 BUSY SHALL be high exactly in MUL and DIV.
REQ-020 Writes to addresses 0-3 while BUSY SHALL be ignored; operands are latched at start.
REQ-021 Reads while BUSY SHALL return the current (partial) register contents without disturbing the operation.
REQ-022 DONE SHALL stay set until the next start; reading status SHALL NOT clear it.
REQ-023 RDY low mid-operation SHALL freeze the counter and datapath, extending latency by the stall count.

Reset
REQ-024 reset SHALL force IDLE, counter 0, all operand/result/remainder registers 0, DONE=0, DZ=0, DO=0 and BUSY=0, including when reset is asserted mid-operation, and SHALL take priority over RDY.

Configuration
REQ-025 Macro MULDIV_DIV_EN: when defined, the divider, the DIV state, the remainder register and DZ SHALL be present; when undefined, control bit1 SHALL be ignored, and the address 1 write, remainder read and DZ SHALL read as 0. Multiply behaviour is identical in both builds.

Structure
REQ-026 Shared package muldiv_pkg SHALL hold the register address constants, control/status bit positions and FSM state encoding.
REQ-027 One sub-module, muldiv_step, SHALL implement the combinational per-cycle add/shift (multiply) and trial-subtract (divide) step; the FSM and registers stay in the top level.

Verification
REQ-028 Write A=0x0C, B=0x0D, start multiply -> BUSY for 8 cycles, then result 0x009C, DONE=1.
REQ-029 Write A=0xFF, B=0xFF, start multiply -> result low 0x01, result high 0xFE.
REQ-030 Write dividend 0x1234, divisor 0x10, start divide -> BUSY for 16 cycles, then quotient 0x0123, remainder 0x04, DZ=0.
REQ-031 Write dividend 0x00AB, divisor 0, start divide -> after 1 cycle quotient 0xFFFF, remainder 0xAB, status 0x41.
REQ-032 Start multiply, write B=0x55 and a second start while BUSY, then drop RDY for 3 cycles -> result uses the original B, completes after 11 cycles, and the second start is ignored.
REQ-033 Assert reset at divide cycle 7 -> next cycle BUSY=0, and all reads return 0x00.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared widths, register map, control/status bit positions,
// FSM encoding and bus request payload for muldiv_65ce02.
package muldiv_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 2;

  // Write map
  localparam logic [ADDR_W-1:0] ADDR_A_LO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_A_HI = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_B    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(3);

  // Read map
  localparam logic [ADDR_W-1:0] ADDR_RES_LO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_RES_HI = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_REM    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(3);

  // Control register bits
  localparam int unsigned CTRL_MUL_BIT = 0;
  localparam int unsigned CTRL_DIV_BIT = 1;

  // Status register bits
  localparam int unsigned STAT_DONE_BIT = 0;
  localparam int unsigned STAT_DZ_BIT   = 6;
  localparam int unsigned STAT_BUSY_BIT = 7;

  // Final step index of each operation
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(15);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  typedef struct packed {
    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] ab;
    logic [DATA_W-1:0] di;
  } bus_req_t;

endpackage

// File: rtl/muldiv_65ce02_if.sv
// muldiv_65ce02_if: register access bus of the multiply/divide unit.
interface muldiv_65ce02_if;
  import muldiv_pkg::*;

  logic              CS;
  logic              WE;
  logic [ADDR_W-1:0] AB;
  logic [DATA_W-1:0] DI;
  logic [DATA_W-1:0] DO;
  logic              BUSY;

  modport master (output CS, WE, AB, DI, input DO, BUSY);
  modport slave  (input CS, WE, AB, DI, output DO, BUSY);

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply and,
// when MULDIV_DIV_EN is defined, one restoring-division trial subtract.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic [RES_W-1:0]  acc,
  input  logic [DATA_W-1:0] opnd,
`ifdef MULDIV_DIV_EN
  input  logic [DATA_W-1:0] rem,
  output logic [RES_W-1:0]  div_quo_c,
  output logic [DATA_W-1:0] div_rem_c,
`endif
  output logic [RES_W-1:0]  mul_acc_c
);

  logic [DATA_W:0] mul_sum;

  // Multiply: add operand into the upper half when the current multiplier
  // bit is set, then shift the whole accumulator right by one.
  always_comb begin
    mul_sum   = {1'b0, acc[RES_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_acc_c = {mul_sum, acc[DATA_W-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] diff;

  // Divide: shift the next dividend bit into the partial remainder and keep
  // the difference only when it does not go negative. The difference always
  // fits in 8 bits because the remainder stays below the divisor.
  always_comb begin
    trial = {rem, acc[RES_W-1]};
    diff  = trial[DATA_W-1:0] - opnd;
    if (trial >= {1'b0, opnd}) begin
      div_rem_c = diff;
      div_quo_c = {acc[RES_W-2:0], 1'b1};
    end else begin
      div_rem_c = trial[DATA_W-1:0];
      div_quo_c = {acc[RES_W-2:0], 1'b0};
    end
  end
`endif

endmodule

// File: rtl/muldiv_65ce02.sv
// muldiv_65ce02: register-mapped 8x8 multiplier with optional 16/8 divider.
// Optional divider, remainder and divide-by-zero flag: define MULDIV_DIV_EN.
module muldiv_65ce02
  import muldiv_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           RDY,
  muldiv_65ce02_if.slave bus
);

  bus_req_t          req;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] status;
  logic [RES_W-1:0]  mul_acc;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_lo_q, a_lo_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic [DATA_W-1:0] do_q, do_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

`ifdef MULDIV_DIV_EN
  logic [DATA_W-1:0] a_hi_q, a_hi_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              dz_q, dz_d;
  logic [RES_W-1:0]  div_quo;
  logic [DATA_W-1:0] div_rem;
`endif

  assign req   = '{cs: bus.CS, we: bus.WE, ab: bus.AB, di: bus.DI};
  assign wr_en = req.cs & req.we;
  assign rd_en = req.cs & ~req.we;

  assign bus.DO   = do_q;
  assign bus.BUSY = busy_q;

  muldiv_step u_step (
    .acc       (res_q),
    .opnd      (b_q),
`ifdef MULDIV_DIV_EN
    .rem       (rem_q),
    .div_quo_c (div_quo),
    .div_rem_c (div_rem),
`endif
    .mul_acc_c (mul_acc)
  );

  // Read data mux over the live result/remainder/status registers.
  always_comb begin
    status                = '0;
    status[STAT_BUSY_BIT] = busy_q;
    status[STAT_DONE_BIT] = done_q;
`ifdef MULDIV_DIV_EN
    status[STAT_DZ_BIT]   = dz_q;
`endif
    case (req.ab)
      ADDR_RES_LO: rd_data = res_q[DATA_W-1:0];
      ADDR_RES_HI: rd_data = res_q[RES_W-1:DATA_W];
`ifdef MULDIV_DIV_EN
      ADDR_REM:    rd_data = rem_q;
`else
      ADDR_REM:    rd_data = '0;
`endif
      default:     rd_data = status;
    endcase
  end

  // Next-state, datapath and read-port update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_lo_d  = a_lo_q;
    b_d     = b_q;
    res_d   = res_q;
    done_d  = done_q;
    do_d    = do_q;
`ifdef MULDIV_DIV_EN
    a_hi_d  = a_hi_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`endif

    if (rd_en) begin
      do_d = rd_data;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (wr_en) begin
          case (req.ab)
            ADDR_A_LO: a_lo_d = req.di;
            ADDR_A_HI: begin
`ifdef MULDIV_DIV_EN
              a_hi_d = req.di;
`endif
            end
            ADDR_B:    b_d = req.di;
            default: begin
              if (req.di[CTRL_MUL_BIT]) begin
                state_d = ST_MUL;
                res_d   = {DATA_W'(0), a_lo_q};
                done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
                dz_d    = 1'b0;
`endif
              end
`ifdef MULDIV_DIV_EN
              else if (req.di[CTRL_DIV_BIT]) begin
                state_d = ST_DIV;
                res_d   = {a_hi_q, a_lo_q};
                rem_d   = '0;
                done_d  = 1'b0;
                dz_d    = 1'b0;
              end
`endif
            end
          endcase
        end
      end

      ST_MUL: begin
        res_d = mul_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == MUL_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end

`ifdef MULDIV_DIV_EN
      ST_DIV: begin
        if (b_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          res_d   = '1;
          rem_d   = a_lo_q;
          dz_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          res_d = div_quo;
          rem_d = div_rem;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == DIV_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and register update; reset wins over the RDY stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_lo_q  <= '0;
      b_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      do_q    <= '0;
      busy_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      a_hi_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
`endif
    end else if (RDY) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_lo_q  <= a_lo_d;
      b_q     <= b_d;
      res_q   <= res_d;
      done_q  <= done_d;
      do_q    <= do_d;
      busy_q  <= busy_d;
`ifdef MULDIV_DIV_EN
      a_hi_q  <= a_hi_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_65ce02.sv
// tb_muldiv_65ce02: vector table, randomized model comparison and hand
// sequences for stall, busy-write protection and mid-operation reset.
module tb_muldiv_65ce02;

  logic clk = 1'b0;
  logic reset;
  logic RDY;

  muldiv_65ce02_if bus();

  muldiv_65ce02 dut (
    .clk   (clk),
    .reset (reset),
    .RDY   (RDY),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  ctrl;
    logic [15:0] dvd;
    logic [7:0]  dsr;
    logic [15:0] exp_res;
    logic [7:0]  exp_rem;
    logic [7:0]  exp_stat;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    bus.CS = 1'b1; bus.WE = 1'b1; bus.AB = addr; bus.DI = data;
    tick();
    bus.CS = 1'b0; bus.WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] addr, output logic [7:0] data);
    bus.CS = 1'b1; bus.WE = 1'b0; bus.AB = addr;
    tick();
    bus.CS = 1'b0;
    data = bus.DO;
  endtask

  task automatic wait_idle(inout int cyc);
    while (bus.BUSY === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  task automatic do_op(input logic [7:0] ctrl, input logic [15:0] dvd, input logic [7:0] dsr,
                       output int cyc, output logic [15:0] res, output logic [7:0] rm,
                       output logic [7:0] st);
    logic [7:0] lo, hi;
    wr(2'd0, dvd[7:0]);
    wr(2'd1, dvd[15:8]);
    wr(2'd2, dsr);
    wr(2'd3, ctrl);
    cyc = 0;
    wait_idle(cyc);
    rd(2'd0, lo);
    rd(2'd1, hi);
    rd(2'd2, rm);
    rd(2'd3, st);
    res = {hi, lo};
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int          cyc;
    logic [15:0] res;
    logic [7:0]  rm, st;
    bit          chk_rem;
    do_op(v.ctrl, v.dvd, v.dsr, cyc, res, rm, st);
    chk_rem = 1'b1;
`ifdef MULDIV_DIV_EN
    chk_rem = (v.ctrl == 8'h02);
`endif
    chk({tag, "_cycles"}, cyc, v.exp_cyc);
    chk({tag, "_result"}, int'(res), int'(v.exp_res));
    chk({tag, "_status"}, int'(st), int'(v.exp_stat));
    if (chk_rem) chk({tag, "_rem"}, int'(rm), int'(v.exp_rem));
  endtask

  // Behavioural reference for one operation.
  function automatic vec_t model(input logic [7:0] ctrl, input logic [15:0] dvd, input logic [7:0] dsr);
    vec_t v;
    int   a, d, b;
    v.ctrl = ctrl; v.dvd = dvd; v.dsr = dsr;
    a = int'(dvd[7:0]); d = int'(dvd); b = int'(dsr);
    v.exp_stat = 8'h01;
    v.exp_rem  = 8'h00;
    if (ctrl[0]) begin
      v.exp_res = 16'(a * b);
      v.exp_cyc = 8;
    end else if (b == 0) begin
      v.exp_res  = 16'hFFFF;
      v.exp_rem  = dvd[7:0];
      v.exp_stat = 8'h41;
      v.exp_cyc  = 1;
    end else begin
      v.exp_res = 16'(d / b);
      v.exp_rem = 8'(d % b);
      v.exp_cyc = 16;
    end
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d8, st0;
    logic [15:0] exp16;
    int          cyc, a, b;

    reset = 1'b1; RDY = 1'b1;
    bus.CS = 1'b0; bus.WE = 1'b0; bus.AB = 2'd0; bus.DI = 8'h00;

    // Reset state
    tick(); tick();
    chk("reset_busy", int'(bus.BUSY), 0);
    chk("reset_do", int'(bus.DO), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d8);
      chk($sformatf("reset_rd%0d", i), int'(d8), 0);
    end

    // Directed vectors
    vecs.push_back('{8'h01, 16'h000C, 8'h0D, 16'h009C, 8'h00, 8'h01, 8});
    vecs.push_back('{8'h01, 16'h00FF, 8'hFF, 16'hFE01, 8'h00, 8'h01, 8});
    vecs.push_back('{8'h03, 16'h0080, 8'h02, 16'h0100, 8'h00, 8'h01, 8});
    vecs.push_back('{8'h01, 16'h0000, 8'h80, 16'h0000, 8'h00, 8'h01, 8});
    vecs.push_back('{8'h01, 16'h0001, 8'h01, 16'h0001, 8'h00, 8'h01, 8});
    vecs.push_back('{8'h01, 16'h5A07, 8'h03, 16'h0015, 8'h00, 8'h01, 8});
`ifdef MULDIV_DIV_EN
    vecs.push_back('{8'h02, 16'h1234, 8'h10, 16'h0123, 8'h04, 8'h01, 16});
    vecs.push_back('{8'h02, 16'h00AB, 8'h00, 16'hFFFF, 8'hAB, 8'h41, 1});
    vecs.push_back('{8'h02, 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 8'h01, 16});
    vecs.push_back('{8'h02, 16'h0005, 8'h07, 16'h0000, 8'h05, 8'h01, 16});
    vecs.push_back('{8'h02, 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 8'h01, 16});
    vecs.push_back('{8'h01, 16'h0003, 8'h05, 16'h000F, 8'h00, 8'h01, 8});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Randomized against the reference model
    for (int i = 0; i < 20; i++) begin
      run_vec($sformatf("rmul%0d", i),
              model(8'h01, 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255))));
    end
`ifdef MULDIV_DIV_EN
    for (int i = 0; i < 20; i++) begin
      run_vec($sformatf("rdiv%0d", i),
              model(8'h02, 16'($urandom_range(0, 65535)),
                    (i % 5 == 0) ? 8'h00 : 8'($urandom_range(1, 255))));
    end
`endif

    // Busy writes ignored, RDY stall extends latency, DO held while stalled
    a = 157; b = 59;
    exp16 = 16'(a * b);
    wr(2'd0, 8'(a));
    wr(2'd2, 8'(b));
    wr(2'd3, 8'h01);
    cyc = 0;
    wr(2'd2, 8'h55); cyc++;
    wr(2'd3, 8'h01); cyc++;
    rd(2'd3, st0);   cyc++;
    chk("stall_busy_status", int'(st0), 8'h80);
    RDY = 1'b0;
    bus.CS = 1'b1; bus.WE = 1'b0; bus.AB = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick(); cyc++;
    end
    chk("stall_do_hold", int'(bus.DO), 8'h80);
    bus.CS = 1'b0;
    RDY = 1'b1;
    wait_idle(cyc);
    chk("stall_cycles", cyc, 11);
    rd(2'd0, d8); chk("stall_res_lo", int'(d8), int'(exp16[7:0]));
    rd(2'd1, d8); chk("stall_res_hi", int'(d8), int'(exp16[15:8]));
    rd(2'd3, d8); chk("stall_status", int'(d8), 8'h01);
    rd(2'd3, d8); chk("done_sticky", int'(d8), 8'h01);
    // B kept its original value: rerun with only a start
    wr(2'd3, 8'h01);
    cyc = 0;
    wait_idle(cyc);
    chk("rerun_cycles", cyc, 8);
    rd(2'd0, d8); chk("rerun_res_lo", int'(d8), int'(exp16[7:0]));
    rd(2'd1, d8); chk("rerun_res_hi", int'(d8), int'(exp16[15:8]));

`ifndef MULDIV_DIV_EN
    // Divider absent: bit1 is not a start, address 1 write has no effect
    wr(2'd1, 8'h77);
    wr(2'd3, 8'h02);
    chk("nodiv_busy", int'(bus.BUSY), 0);
    rd(2'd1, d8); chk("nodiv_res_hi", int'(d8), int'(exp16[15:8]));
    rd(2'd2, d8); chk("nodiv_rem", int'(d8), 0);
    rd(2'd3, d8); chk("nodiv_status", int'(d8), 8'h01);
`endif

    // Reset in the middle of an operation
`ifdef MULDIV_DIV_EN
    wr(2'd0, 8'h34); wr(2'd1, 8'h12); wr(2'd2, 8'h10);
    wr(2'd3, 8'h02);
    for (int i = 0; i < 6; i++) tick();
`else
    wr(2'd0, 8'hFF); wr(2'd2, 8'hFF);
    wr(2'd3, 8'h01);
    for (int i = 0; i < 4; i++) tick();
`endif
    chk("midop_busy", int'(bus.BUSY), 1);
    reset = 1'b1;
    RDY = 1'b0;
    tick();
    reset = 1'b0;
    RDY = 1'b1;
    chk("midrst_busy", int'(bus.BUSY), 0);
    chk("midrst_do", int'(bus.DO), 0);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d8);
      chk($sformatf("midrst_rd%0d", i), int'(d8), 0);
    end
    // Operands cleared by reset: bare start yields zero
    wr(2'd3, 8'h01);
    cyc = 0;
    wait_idle(cyc);
    chk("post_rst_cycles", cyc, 8);
    rd(2'd0, d8); chk("post_rst_lo", int'(d8), 0);
    rd(2'd3, d8); chk("post_rst_status", int'(d8), 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
